// File: rtl/parity_engine.sv
// Parity generator plus serial parity checker (IDLE/DATA/PAR FSM).
// Define PAR_ERR_CNT_EN to add err_clr/err_cnt saturating error counter.
module parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic                  busy,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    output logic                  par_bit,
    input  logic                  chk_start,
    input  logic                  chk_bit_valid,
    input  logic                  chk_bit,
    output logic                  chk_busy,
    output logic                  chk_done,
`ifdef PAR_ERR_CNT_EN
    output logic                  par_err,
    input  logic                  err_clr,
    output logic [CNT_WIDTH-1:0]  err_cnt
`else
    output logic                  par_err
`endif
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] gen_data;
    logic                  gen_en;
    logic [1:0]            gen_mode;

    logic          acc, acc_n;
    logic [BW-1:0] cnt, cnt_n;
    logic          chk_en, chk_en_n;
    logic [1:0]    chk_mode, chk_mode_n;
    logic          done_n, err_n;
    logic          exp_bit;

    function automatic logic par_of(input logic x, input logic [1:0] m);
        unique case (m)
            2'b00:   par_of = x;
            2'b01:   par_of = ~x;
            2'b10:   par_of = 1'b1;
            default: par_of = 1'b0;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            gen_data <= '0;
            gen_en   <= 1'b0;
            gen_mode <= 2'b00;
        end else if (Data_Valid && !busy) begin
            gen_data <= P_DATA;
            gen_en   <= PAR_EN;
            gen_mode <= PAR_MODE;
        end
    end

    always_comb begin
        par_bit = 1'b0;
        if (gen_en)
            par_bit = par_of(^gen_data, gen_mode);
    end

    assign exp_bit  = par_of(acc, chk_mode);
    assign chk_busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            acc      <= 1'b0;
            cnt      <= '0;
            chk_en   <= 1'b0;
            chk_mode <= 2'b00;
            chk_done <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            chk_en   <= chk_en_n;
            chk_mode <= chk_mode_n;
            chk_done <= done_n;
            par_err  <= err_n;
        end
    end

    // chk_start restarts from any state, which also aborts a character
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = cnt;
        chk_en_n   = chk_en;
        chk_mode_n = chk_mode;
        done_n     = 1'b0;
        err_n      = 1'b0;
        if (chk_start) begin
            state_n    = DATA;
            acc_n      = 1'b0;
            cnt_n      = '0;
            chk_en_n   = PAR_EN;
            chk_mode_n = PAR_MODE;
        end else begin
            unique case (state)
                DATA: begin
                    if (chk_bit_valid) begin
                        acc_n = acc ^ chk_bit;
                        if (cnt == LAST) begin
                            cnt_n = '0;
                            if (chk_en) begin
                                state_n = PAR;
                            end else begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (chk_bit_valid) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        err_n   = (chk_bit != exp_bit);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PAR_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST || err_clr)
            err_cnt <= '0;
        else if (par_err && (err_cnt != {CNT_WIDTH{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine: generator modes, checker, abort, reset.
// Error-counter checks compile only with PAR_ERR_CNT_EN defined.
module tb_parity_engine;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Data_Valid = 1'b0;
    logic          busy = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          PAR_EN = 1'b0;
    logic [1:0]    PAR_MODE = 2'b00;
    logic          par_bit;
    logic          chk_start = 1'b0;
    logic          chk_bit_valid = 1'b0;
    logic          chk_bit = 1'b0;
    logic          chk_busy;
    logic          chk_done;
    logic          par_err;
`ifdef PAR_ERR_CNT_EN
    logic          err_clr = 1'b0;
    logic [CW-1:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err = 0;
    int exp_done = 0;
    int exp_err = 0;

    parity_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .Data_Valid(Data_Valid),
        .busy(busy),
        .P_DATA(P_DATA),
        .PAR_EN(PAR_EN),
        .PAR_MODE(PAR_MODE),
        .par_bit(par_bit),
        .chk_start(chk_start),
        .chk_bit_valid(chk_bit_valid),
        .chk_bit(chk_bit),
        .chk_busy(chk_busy),
        .chk_done(chk_done),
`ifdef PAR_ERR_CNT_EN
        .par_err(par_err),
        .err_clr(err_clr),
        .err_cnt(err_cnt)
`else
        .par_err(par_err)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (chk_done === 1'b1) n_done++;
        if (par_err === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic gen_load(input logic [DW-1:0] d, input logic en,
                            input logic [1:0] m);
        Data_Valid = 1'b1;
        P_DATA = d;
        PAR_EN = en;
        PAR_MODE = m;
        step();
        Data_Valid = 1'b0;
    endtask

    // A stray valid rides along with chk_start and must be ignored
    task automatic send_char(input logic [DW-1:0] d, input logic en,
                             input logic [1:0] m, input logic pb,
                             input logic gaps, input logic clr);
        PAR_EN = en;
        PAR_MODE = m;
        chk_start = 1'b1;
        chk_bit_valid = 1'b1;
        chk_bit = 1'b1;
        step();
        chk_start = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (gaps && i == 2) begin
                chk_bit_valid = 1'b0;
                repeat (3) step();
                check("stall_busy", 32'(chk_busy), 32'd1);
            end
            chk_bit_valid = 1'b1;
            chk_bit = d[i];
            step();
        end
        if (en) begin
            chk_bit = pb;
            step();
        end
        chk_bit_valid = 1'b0;
`ifdef PAR_ERR_CNT_EN
        err_clr = clr;
`endif
        step();
`ifdef PAR_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        step();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_done"}, 32'(n_done), 32'(exp_done));
        check({tag, "_err"}, 32'(n_err), 32'(exp_err));
    endtask

    initial begin
        repeat (2) step();
        RST = 1'b0;
        step();
        check("rst_par_bit", 32'(par_bit), 32'd0);
        check("rst_busy", 32'(chk_busy), 32'd0);
        check("rst_done", 32'(chk_done), 32'd0);
        check("rst_err", 32'(par_err), 32'd0);
`ifdef PAR_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

        gen_load(8'hA5, 1'b1, 2'b00);
        check("gen_even_a5", 32'(par_bit), 32'd0);
        gen_load(8'hA5, 1'b1, 2'b01);
        check("gen_odd_a5", 32'(par_bit), 32'd1);
        gen_load(8'hA5, 1'b1, 2'b10);
        check("gen_mark", 32'(par_bit), 32'd1);
        gen_load(8'hA5, 1'b1, 2'b11);
        check("gen_space", 32'(par_bit), 32'd0);
        gen_load(8'h01, 1'b1, 2'b00);
        check("gen_even_01", 32'(par_bit), 32'd1);
        gen_load(8'h01, 1'b0, 2'b01);
        check("gen_disabled", 32'(par_bit), 32'd0);

        gen_load(8'hA5, 1'b1, 2'b00);
        busy = 1'b1;
        gen_load(8'h01, 1'b1, 2'b00);
        check("gen_busy_hold", 32'(par_bit), 32'd0);
        busy = 1'b0;
        gen_load(8'h01, 1'b1, 2'b00);
        check("gen_reload", 32'(par_bit), 32'd1);

        // 0x3B has five ones: even parity 1, odd parity 0
        send_char(8'h3B, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_done++;
        check_counts("even_ok");
        send_char(8'h3B, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        exp_done++;
        exp_err++;
        check_counts("even_bad");
`ifdef PAR_ERR_CNT_EN
        check("err_cnt_one", 32'(err_cnt), 32'd1);
`endif
        send_char(8'h3B, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        exp_done++;
        check_counts("odd_stall_ok");
        send_char(8'hA5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_done++;
        exp_err++;
        check_counts("odd_a5_bad");
        send_char(8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        exp_done++;
        exp_err++;
        check_counts("mark_bad");
        send_char(8'hFF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        exp_done++;
        check_counts("space_ok");
        send_char(8'h3B, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        exp_done++;
        check_counts("no_par");
        check("idle_busy", 32'(chk_busy), 32'd0);

        PAR_EN = 1'b1;
        PAR_MODE = 2'b00;
        chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_bit_valid = 1'b1;
            chk_bit = (i == 0);
            step();
        end
        chk_bit_valid = 1'b0;
        check("abort_busy", 32'(chk_busy), 32'd1);
        send_char(8'h3B, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_done++;
        check_counts("abort");

        chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_bit_valid = 1'b1;
            chk_bit = 1'b1;
            step();
        end
        chk_bit_valid = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_bit_valid = 1'b0;
        check("mid_rst_busy", 32'(chk_busy), 32'd0);
        check("mid_rst_par_bit", 32'(par_bit), 32'd0);
        repeat (3) step();
        check_counts("mid_rst");
`ifdef PAR_ERR_CNT_EN
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        send_char(8'h3B, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_done++;
        check_counts("post_rst_ok");
        send_char(8'h3B, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        exp_done++;
        exp_err++;
        check_counts("post_rst_bad");

`ifdef PAR_ERR_CNT_EN
        for (int k = 0; k < 5; k++) begin
            send_char(8'h3B, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
            exp_done++;
            exp_err++;
        end
        check_counts("sat_run");
        check("err_cnt_sat", 32'(err_cnt), 32'd3);
        send_char(8'h3B, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        exp_done++;
        exp_err++;
        check("err_cnt_clr", 32'(err_cnt), 32'd0);
        send_char(8'h3B, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        exp_done++;
        exp_err++;
        check("err_cnt_after_clr", 32'(err_cnt), 32'd1);
        check_counts("clr_run");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
